// File: rtl/spad_seq_ctrl.sv
// rtl/spad_seq_ctrl.sv - scratchpad fill and 1-D convolution read sequencer (optional SPAD_SEQ_CTRL_PERF_CNT_EN adds stall_cnt_o)
module spad_seq_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [A_WIDTH:0]   cfg_len_i,
  input  logic [A_WIDTH-1:0] cfg_k_i,
  input  logic [A_WIDTH-1:0] cfg_out_i,
  input  logic [A_WIDTH-1:0] cfg_stride_i,
  input  logic               in_valid_i,
  input  logic [D_WIDTH-1:0] in_data_i,
  output logic               in_ready_o,
  input  logic               stall_i,
  output logic               spad_wen_o,
  output logic [A_WIDTH-1:0] spad_w_addr_o,
  output logic [D_WIDTH-1:0] spad_w_data_o,
  output logic               spad_ren_o,
  output logic [A_WIDTH-1:0] spad_r_addr_o,
  output logic               rd_valid_o,
  output logic               rd_first_o,
  output logic               rd_last_o,
  output logic               busy_o,
  output logic               done_o
`ifdef SPAD_SEQ_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [A_WIDTH-1:0] ONE_A = {{(A_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [A_WIDTH:0]   ONE_L = {{A_WIDTH{1'b0}}, 1'b1};

  state_e state_q, state_d;

  // Job configuration, frozen at start so changes while busy have no effect.
  // cfg_out_q is stored as 0 whenever the job issues no reads (out=0 or k=0).
  logic [A_WIDTH:0]   cfg_len_q, cfg_len_d;
  logic [A_WIDTH-1:0] cfg_k_q, cfg_k_d;
  logic [A_WIDTH-1:0] cfg_out_q, cfg_out_d;
  logic [A_WIDTH-1:0] cfg_stride_q, cfg_stride_d;

  // Load beat counter, tap index, output index and running o*stride base.
  logic [A_WIDTH:0]   beat_q, beat_d;
  logic [A_WIDTH-1:0] tap_q, tap_d;
  logic [A_WIDTH-1:0] pos_q, pos_d;
  logic [A_WIDTH-1:0] base_q, base_d;

  // Read markers aligned with the scratchpad's one-cycle read latency.
  logic rd_valid_q, rd_first_q, rd_last_q;

  logic no_reads;
  logic tap_first;
  logic tap_last;

  assign no_reads  = (cfg_out_i == '0) || (cfg_k_i == '0);
  assign tap_first = (tap_q == '0);
  assign tap_last  = (tap_q == (cfg_k_q - ONE_A));

  // State register plus all job counters and latched configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cfg_len_q    <= '0;
      cfg_k_q      <= '0;
      cfg_out_q    <= '0;
      cfg_stride_q <= '0;
      beat_q       <= '0;
      tap_q        <= '0;
      pos_q        <= '0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      cfg_len_q    <= cfg_len_d;
      cfg_k_q      <= cfg_k_d;
      cfg_out_q    <= cfg_out_d;
      cfg_stride_q <= cfg_stride_d;
      beat_q       <= beat_d;
      tap_q        <= tap_d;
      pos_q        <= pos_d;
      base_q       <= base_d;
    end
  end

  // Next-state, counter updates and the combinational strobes.
  always_comb begin
    state_d      = state_q;
    cfg_len_d    = cfg_len_q;
    cfg_k_d      = cfg_k_q;
    cfg_out_d    = cfg_out_q;
    cfg_stride_d = cfg_stride_q;
    beat_d       = beat_q;
    tap_d        = tap_q;
    pos_d        = pos_q;
    base_d       = base_q;
    in_ready_o   = 1'b0;
    spad_wen_o   = 1'b0;
    spad_ren_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_len_d    = cfg_len_i;
          cfg_k_d      = cfg_k_i;
          cfg_out_d    = no_reads ? '0 : cfg_out_i;
          cfg_stride_d = cfg_stride_i;
          beat_d       = '0;
          tap_d        = '0;
          pos_d        = '0;
          base_d       = '0;
          if (cfg_len_i != '0) begin
            state_d = S_LOAD;
          end else if (no_reads) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_LOAD: begin
        in_ready_o = 1'b1;
        spad_wen_o = in_valid_i;
        if (in_valid_i) begin
          beat_d = beat_q + ONE_L;
          if (beat_q == (cfg_len_q - ONE_L)) begin
            state_d = (cfg_out_q == '0) ? S_DONE : S_RUN;
          end
        end
      end

      S_RUN: begin
        if (!stall_i) begin
          spad_ren_o = 1'b1;
          if (tap_last) begin
            tap_d  = '0;
            pos_d  = pos_q + ONE_A;
            base_d = base_q + cfg_stride_q;
            if (pos_q == (cfg_out_q - ONE_A)) begin
              state_d = S_DONE;
            end
          end else begin
            tap_d = tap_q + ONE_A;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        beat_d  = '0;
        tap_d   = '0;
        pos_d   = '0;
        base_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered read markers: the word read this cycle is valid next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= spad_ren_o;
      rd_first_q <= spad_ren_o & tap_first;
      rd_last_q  <= spad_ren_o & tap_last;
    end
  end

  assign spad_w_addr_o = beat_q[A_WIDTH-1:0];
  assign spad_w_data_o = in_data_i;
  assign spad_r_addr_o = base_q + tap_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_first_o    = rd_first_q;
  assign rd_last_o     = rd_last_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

`ifdef SPAD_SEQ_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        start_acc;

  assign start_acc = (state_q == S_IDLE) && start_i;

  // Stalled-RUN cycle counter: cleared per job, saturating, held after done.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_RUN) && stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
